pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Drives stall/flush enables for all four pipeline registers, including the MEM->WB register.
//  Produces the forwarding selects for EX and for branch compare in ID.
//  A registered FSM holds the pipeline while a multi-cycle data-memory access is in MEM.
// PARAMETERS
//  REG_W        5    register-index width
//  MEM_TIMEOUT  255  max wait cycles on mem_ready before ERROR (1..65535)
// PORTS
//  clk          in   1      pipeline clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  RsD,RtD      in   REG_W  source regs in ID
//  RsE,RtE      in   REG_W  source regs in EX
//  WriteRegE/M/W in  REG_W  destination reg in EX/MEM/WB
//  RegWriteE/M/W in  1      destination write enable per stage
//  MemtoRegE/M  in   1      load in EX/MEM
//  BranchD      in   1      branch decoded in ID
//  PCSrcD       in   1      branch taken / jump resolved in ID
//  MemAccessM   in   1      load/store occupying MEM
//  mem_ready    in   1      data memory completes access this cycle
//  StallF,StallD,StallE,StallM out 1  hold PC / IF_ID / ID_EX / EX_MEM
//  FlushD,FlushE,FlushW out 1   zero IF_ID / ID_EX / MEM_WB (bubble) next edge
//  ForwardAE,ForwardBE out 2    EX operand select: 00 regfile, 01 WB, 10 MEM
//  ForwardAD,ForwardBD out 1    ID compare takes ALUOut_M
//  mem_err      out  1      sticky memory-timeout flag
// BEHAVIOUR
//  - Forwarding, pure combinational; r0 is never forwarded (WriteReg==0 -> no match):
//    ForwardAE=10 if RegWriteM & WriteRegM==RsE, else 01 if RegWriteW & WriteRegW==RsE,
//    else 00. MEM has priority over WB. B side identical with RtE.
//    ForwardAD = RegWriteM & WriteRegM==RsD; BD with RtD.
//  - lwstall = MemtoRegE & (WriteRegE==RsD | WriteRegE==RtD), WriteRegE!=0.
//  - brstall = BranchD & ((RegWriteE & WriteRegE in {RsD,RtD}) |
//    (MemtoRegM & WriteRegM in {RsD,RtD})), WriteReg!=0.
//  - FSM states RUN, MEM_WAIT, ERROR (registered; reset -> RUN, wait_cnt=0, mem_err=0).
//  - RUN:
//    MemAccessM & !mem_ready -> MEM_WAIT; outputs this cycle already as MEM_WAIT.
//    Otherwise lw/brstall -> StallF=StallD=FlushE=1.
//    PCSrcD & !stall -> FlushD=1 for exactly one cycle.
//  - MEM_WAIT:
//    StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; wait_cnt++ each cycle.
//    mem_ready=1 -> RUN; that cycle stalls drop and MEM advances normally.
//    wait_cnt==MEM_TIMEOUT & !mem_ready -> ERROR.
//  - ERROR: all Stall*=1, FlushW=1, mem_err=1 held until rst_n low; no exit otherwise.
//  - Priority: ERROR > MEM_WAIT > lw/brstall > PCSrcD flush.
//  - Simultaneous: lwstall with PCSrcD -> stall wins, FlushD=0 (branch re-evaluated next cycle).
//  - rst_n low mid-access: immediately RUN, counters cleared, mem_err=0.
//  - wait_cnt cleared on every entry to MEM_WAIT; never wraps (bounded by MEM_TIMEOUT).
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined:
//    - Adds outputs perf_stall_cnt[31:0] (cycles with StallF=1) and perf_flush_cnt[31:0]
//      (cycles with FlushD|FlushE=1).
//    - Both are saturating at 32'hFFFF_FFFF and cleared by rst_n.
//  PIPE_HAZARD_PERF_EN undefined: ports and counters absent; all else identical.
// STRUCTURE
//  Package pipe_ctrl_pkg:
//    - state enum {RUN, MEM_WAIT, ERROR};
//    - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
//  Sub-module pipe_fwd_unit: combinational forwarding selects and lw/brstall.
//  Top holds the FSM, wait counter and optional perf counters.
// TESTING
//  - R-type chain: EX writes $8 (RegWriteM, WriteRegM=8), RsE=8, WriteRegW=8 also
//    -> ForwardAE=10 (MEM priority).
//  - Load-use: MemtoRegE=1, WriteRegE=9, RtD=9 -> StallF=StallD=FlushE=1 for 1 cycle, then 0.
//  - Branch: PCSrcD=1, no hazard -> FlushD=1 exactly one cycle;
//    with lwstall same cycle -> FlushD=0.
//  - Memory wait: MemAccessM=1, mem_ready low 3 cycles -> Stall* and FlushW high 3 cycles,
//    released on ready.
//  - Timeout: MEM_TIMEOUT=4, mem_ready never -> ERROR after 4 wait cycles, mem_err=1;
//    rst_n pulse -> RUN, mem_err=0.
//  - WriteReg=0 hazards: WriteRegM=0, RsE=0, RegWriteM=1 -> ForwardAE=00, no stalls.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Holds the controller FSM state type and the EX forwarding select encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// The pipeline datapath is the master; the hazard controller is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
);

    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic [REG_W-1:0] RsE;
    logic [REG_W-1:0] RtE;
    logic [REG_W-1:0] WriteRegE;
    logic [REG_W-1:0] WriteRegM;
    logic [REG_W-1:0] WriteRegW;
    logic             RegWriteE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             MemtoRegM;
    logic             BranchD;
    logic             PCSrcD;
    logic             MemAccessM;
    logic             mem_ready;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             ForwardAD;
    logic             ForwardBD;
    logic             mem_err;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        output BranchD, PCSrcD, MemAccessM, mem_ready,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, mem_err
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        input  BranchD, PCSrcD, MemAccessM, mem_ready,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD, mem_err
    );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Combinational forwarding selects for EX and the ID branch compare,
// plus load-use and branch-operand stall detection. Register 0 never matches.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] i_rs_d,
    input  logic [REG_W-1:0] i_rt_d,
    input  logic [REG_W-1:0] i_rs_e,
    input  logic [REG_W-1:0] i_rt_e,
    input  logic [REG_W-1:0] i_write_reg_e,
    input  logic [REG_W-1:0] i_write_reg_m,
    input  logic [REG_W-1:0] i_write_reg_w,
    input  logic             i_reg_write_e,
    input  logic             i_reg_write_m,
    input  logic             i_reg_write_w,
    input  logic             i_mem_to_reg_e,
    input  logic             i_mem_to_reg_m,
    input  logic             i_branch_d,
    output logic [1:0]       o_fwd_a_e,
    output logic [1:0]       o_fwd_b_e,
    output logic             o_fwd_a_d,
    output logic             o_fwd_b_d,
    output logic             o_lw_stall,
    output logic             o_br_stall
);

    function automatic logic hit(input logic             en,
                                 input logic [REG_W-1:0] dst,
                                 input logic [REG_W-1:0] src);
        return en && (dst != '0) && (dst == src);
    endfunction

    logic w_m_hit_rs_e;
    logic w_m_hit_rt_e;
    logic w_w_hit_rs_e;
    logic w_w_hit_rt_e;
    logic w_e_wr_hit_d;
    logic w_e_ld_hit_d;
    logic w_m_ld_hit_d;

    always_comb begin
        w_m_hit_rs_e = hit(i_reg_write_m, i_write_reg_m, i_rs_e);
        w_m_hit_rt_e = hit(i_reg_write_m, i_write_reg_m, i_rt_e);
        w_w_hit_rs_e = hit(i_reg_write_w, i_write_reg_w, i_rs_e);
        w_w_hit_rt_e = hit(i_reg_write_w, i_write_reg_w, i_rt_e);

        o_fwd_a_e = fwd_sel(w_m_hit_rs_e, w_w_hit_rs_e);
        o_fwd_b_e = fwd_sel(w_m_hit_rt_e, w_w_hit_rt_e);
        o_fwd_a_d = hit(i_reg_write_m, i_write_reg_m, i_rs_d);
        o_fwd_b_d = hit(i_reg_write_m, i_write_reg_m, i_rt_d);

        w_e_ld_hit_d = hit(i_mem_to_reg_e, i_write_reg_e, i_rs_d)
                     | hit(i_mem_to_reg_e, i_write_reg_e, i_rt_d);
        w_e_wr_hit_d = hit(i_reg_write_e, i_write_reg_e, i_rs_d)
                     | hit(i_reg_write_e, i_write_reg_e, i_rt_d);
        w_m_ld_hit_d = hit(i_mem_to_reg_m, i_write_reg_m, i_rs_d)
                     | hit(i_mem_to_reg_m, i_write_reg_m, i_rt_d);

        o_lw_stall = w_e_ld_hit_d;
        // The branch compare in ID needs its operands now; an ALU result still in
        // EX or a load still in MEM cannot be forwarded in time.
        o_br_stall = i_branch_d & (w_e_wr_hit_d | w_m_ld_hit_d);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EX/MEM/WB pipeline.
// Define PIPE_HAZARD_PERF_EN to add saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_nxt;
    logic [15:0] w_wait_inc;
    logic        r_mem_err;
    logic        w_mem_hold;

    logic        w_lw_stall;
    logic        w_br_stall;
    logic        w_stall_f;
    logic        w_stall_d;
    logic        w_stall_e;
    logic        w_stall_m;
    logic        w_flush_d;
    logic        w_flush_e;
    logic        w_flush_w;

    pipe_fwd_unit #(
        .REG_W (REG_W)
    ) u_fwd (
        .i_rs_d         (hz.RsD),
        .i_rt_d         (hz.RtD),
        .i_rs_e         (hz.RsE),
        .i_rt_e         (hz.RtE),
        .i_write_reg_e  (hz.WriteRegE),
        .i_write_reg_m  (hz.WriteRegM),
        .i_write_reg_w  (hz.WriteRegW),
        .i_reg_write_e  (hz.RegWriteE),
        .i_reg_write_m  (hz.RegWriteM),
        .i_reg_write_w  (hz.RegWriteW),
        .i_mem_to_reg_e (hz.MemtoRegE),
        .i_mem_to_reg_m (hz.MemtoRegM),
        .i_branch_d     (hz.BranchD),
        .o_fwd_a_e      (hz.ForwardAE),
        .o_fwd_b_e      (hz.ForwardBE),
        .o_fwd_a_d      (hz.ForwardAD),
        .o_fwd_b_d      (hz.ForwardBD),
        .o_lw_stall     (w_lw_stall),
        .o_br_stall     (w_br_stall)
    );

    assign w_wait_inc = r_wait_cnt + 16'd1;

    // The detecting RUN cycle already stalls, so it counts as the first wait cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_hold     = 1'b0;
        unique case (r_state)
            RUN: begin
                if (hz.MemAccessM && !hz.mem_ready) begin
                    w_mem_hold     = 1'b1;
                    w_wait_cnt_nxt = 16'd1;
                    w_state_nxt    = (TIMEOUT == 16'd1) ? ERROR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = RUN;
                end else begin
                    w_mem_hold     = 1'b1;
                    w_wait_cnt_nxt = w_wait_inc;
                    if (w_wait_inc == TIMEOUT) begin
                        w_state_nxt = ERROR;
                    end
                end
            end
            ERROR: begin
                w_mem_hold = 1'b1;
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (w_mem_hold) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (w_lw_stall || w_br_stall) begin
            // A pending redirect is dropped here; the branch re-resolves next cycle.
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (hz.PCSrcD) begin
            w_flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= r_mem_err | (w_state_nxt == ERROR);
        end
    end

    assign hz.StallF  = w_stall_f;
    assign hz.StallD  = w_stall_d;
    assign hz.StallE  = w_stall_e;
    assign hz.StallM  = w_stall_m;
    assign hz.FlushD  = w_flush_d;
    assign hz.FlushE  = w_flush_e;
    assign hz.FlushW  = w_flush_w;
    assign hz.mem_err = r_mem_err;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_stall_f && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((w_flush_d || w_flush_e) && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-scenario tasks drive one cycle at a time,
// push the expected output vector to a scoreboard queue and pop it when sampling.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst_assert;
        logic [4:0] rs_d;
        logic [4:0] rt_d;
        logic [4:0] rs_e;
        logic [4:0] rt_e;
        logic [4:0] wr_e;
        logic [4:0] wr_m;
        logic [4:0] wr_w;
        logic       rw_e;
        logic       rw_m;
        logic       rw_w;
        logic       m2r_e;
        logic       m2r_m;
        logic       br_d;
        logic       pcsrc_d;
        logic       mem_acc;
        logic       ready;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [13:0] sb_q[$];
    string       nm_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5)) hz ();

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .REG_W       (5),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .hz             (hz)
    );

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,ForwardAD,ForwardBD,mem_err}
    function automatic logic [13:0] mk(input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic fw, input logic [1:0] fae,
                                       input logic [1:0] fbe, input logic fad,
                                       input logic fbd, input logic err);
        return {sf, sd, se, sm, fd, fe, fw, fae, fbe, fad, fbd, err};
    endfunction

    function automatic logic [13:0] outs();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW,
                hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD, hz.mem_err};
    endfunction

    task automatic apply(input stim_t s);
        rst_n         = ~s.rst_assert;
        hz.RsD        = s.rs_d;
        hz.RtD        = s.rt_d;
        hz.RsE        = s.rs_e;
        hz.RtE        = s.rt_e;
        hz.WriteRegE  = s.wr_e;
        hz.WriteRegM  = s.wr_m;
        hz.WriteRegW  = s.wr_w;
        hz.RegWriteE  = s.rw_e;
        hz.RegWriteM  = s.rw_m;
        hz.RegWriteW  = s.rw_w;
        hz.MemtoRegE  = s.m2r_e;
        hz.MemtoRegM  = s.m2r_m;
        hz.BranchD    = s.br_d;
        hz.PCSrcD     = s.pcsrc_d;
        hz.MemAccessM = s.mem_acc;
        hz.mem_ready  = s.ready;
    endtask

    // Drive at the falling edge, record the expectation, settle to just before the rising edge.
    task automatic drive(input stim_t s, input logic [13:0] e, input string n);
        @(negedge clk);
        apply(s);
        sb_q.push_back(e);
        nm_q.push_back(n);
        #4;
    endtask

    task automatic test_reset();
        stim_t s;
        logic [13:0] got;
        logic [13:0] ev;
        string nm;
        s = '0;
        s.rst_assert = 1'b1;
        drive(s, 14'd0, "reset_state");
        got = outs();
        ev  = sb_q.pop_front();
        nm  = nm_q.pop_front();
        n_checks++;
        if (got !== ev) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, got, ev);
        end
    endtask

    task automatic test_forwarding();
        stim_t s[5];
        logic [13:0] e[5];
        string n[5];
        logic [13:0] got;
        logic [13:0] ev;
        string nm;
        s[0] = '0; s[0].rw_m = 1; s[0].wr_m = 8; s[0].rw_w = 1; s[0].wr_w = 8; s[0].rs_e = 8;
        e[0] = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0); n[0] = "fwd_mem_priority";
        s[1] = '0; s[1].rw_w = 1; s[1].wr_w = 8; s[1].rs_e = 8; s[1].rt_e = 8; s[1].wr_m = 8;
        e[1] = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0); n[1] = "fwd_wb_both";
        s[2] = '0; s[2].rw_m = 1; s[2].wr_m = 5; s[2].rt_e = 5; s[2].rw_w = 1; s[2].wr_w = 6;
        s[2].rs_e = 6;
        e[2] = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0); n[2] = "fwd_mixed";
        s[3] = '0; s[3].rw_m = 1; s[3].wr_m = 7; s[3].rs_d = 7; s[3].rt_d = 7;
        e[3] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0); n[3] = "fwd_id_compare";
        s[4] = '0; s[4].wr_m = 8; s[4].rs_e = 8; s[4].wr_w = 3; s[4].rt_e = 3;
        e[4] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0); n[4] = "fwd_no_regwrite";
        for (int i = 0; i < 5; i++) begin
            drive(s[i], e[i], n[i]);
            got = outs();
            ev  = sb_q.pop_front();
            nm  = nm_q.pop_front();
            n_checks++;
            if (got !== ev) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b", nm, got, ev);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[2];
        logic [13:0] e[2];
        string n[2];
        logic [13:0] got;
        logic [13:0] ev;
        string nm;
        s[0] = '0; s[0].m2r_e = 1; s[0].rw_e = 1; s[0].wr_e = 9; s[0].rt_d = 9;
        e[0] = mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0); n[0] = "load_use_stall";
        // Load has moved to MEM behind a bubble; ID operand now forwards from MEM.
        s[1] = '0; s[1].m2r_m = 1; s[1].rw_m = 1; s[1].wr_m = 9; s[1].rt_d = 9;
        e[1] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0); n[1] = "load_use_release";
        for (int i = 0; i < 2; i++) begin
            drive(s[i], e[i], n[i]);
            got = outs();
            ev  = sb_q.pop_front();
            nm  = nm_q.pop_front();
            n_checks++;
            if (got !== ev) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b", nm, got, ev);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[6];
        logic [13:0] e[6];
        string n[6];
        logic [13:0] got;
        logic [13:0] ev;
        string nm;
        s[0] = '0; s[0].br_d = 1; s[0].pcsrc_d = 1;
        e[0] = mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0); n[0] = "branch_flush";
        s[1] = '0;
        e[1] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0); n[1] = "branch_flush_end";
        s[2] = '0; s[2].br_d = 1; s[2].pcsrc_d = 1; s[2].m2r_e = 1; s[2].wr_e = 3;
        s[2].rs_d = 3;
        e[2] = mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0); n[2] = "branch_vs_lwstall";
        s[3] = '0; s[3].br_d = 1; s[3].pcsrc_d = 1; s[3].rw_e = 1; s[3].wr_e = 4;
        s[3].rs_d = 4;
        e[3] = mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0); n[3] = "brstall_ex_alu";
        s[4] = '0; s[4].br_d = 1; s[4].pcsrc_d = 1; s[4].m2r_m = 1; s[4].rw_m = 1;
        s[4].wr_m = 6; s[4].rt_d = 6;
        e[4] = mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0); n[4] = "brstall_mem_load";
        s[5] = '0;
        e[5] = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0); n[5] = "branch_idle";
        for (int i = 0; i < 6; i++) begin
            drive(s[i], e[i], n[i]);
            got = outs();
            ev  = sb_q.pop_front();
            nm  = nm_q.pop_front();
            n_checks++;
            if (got !== ev) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b", nm, got, ev);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[5];
        logic [13:0] e[5];
        string n[5];
        logic [13:0] w;
        logic [13:0] got;
        logic [13:0] ev;
        string nm;
        w = mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        s[0] = '0; s[0].mem_acc = 1;
        e[0] = w; n[0] = "mem_wait_c1";
        // A load-use hazard and a taken branch are both outranked by the memory hold.
        s[1] = '0; s[1].mem_acc = 1; s[1].m2r_e = 1; s[1].wr_e = 9; s[1].rt_d = 9;
        s[1].pcsrc_d = 1;
        e[1] = w; n[1] = "mem_wait_c2_priority";
        s[2] = '0; s[2].mem_acc = 1;
        e[2] = w; n[2] = "mem_wait_c3";
        s[3] = '0; s[3].mem_acc = 1; s[3].ready = 1;
        e[3] = 14'd0; n[3] = "mem_wait_release";
        s[4] = '0;
        e[4] = 14'd0; n[4] = "mem_wait_after";
        for (int i = 0; i < 5; i++) begin
            drive(s[i], e[i], n[i]);
            got = outs();
            ev  = sb_q.pop_front();
            nm  = nm_q.pop_front();
            n_checks++;
            if (got !== ev) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b", nm, got, ev);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s[10];
        logic [13:0] e[10];
        string n[10];
        logic [13:0] w;
        logic [13:0] er;
        logic [13:0] got;
        logic [13:0] ev;
        string nm;
        w  = mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        er = mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            s[i] = '0; s[i].mem_acc = 1;
            e[i] = w; n[i] = $sformatf("timeout_wait_%0d", i + 1);
        end
        s[4] = '0; s[4].mem_acc = 1;
        e[4] = er; n[4] = "timeout_error";
        s[5] = '0; s[5].ready = 1; s[5].pcsrc_d = 1;
        e[5] = er; n[5] = "timeout_error_sticky";
        s[6] = '0; s[6].rst_assert = 1;
        e[6] = 14'd0; n[6] = "timeout_reset_async";
        s[7] = '0;
        e[7] = 14'd0; n[7] = "timeout_after_reset";
        s[8] = '0; s[8].mem_acc = 1;
        e[8] = w; n[8] = "timeout_rewait";
        s[9] = '0; s[9].mem_acc = 1; s[9].ready = 1;
        e[9] = 14'd0; n[9] = "timeout_rewait_release";
        for (int i = 0; i < 10; i++) begin
            drive(s[i], e[i], n[i]);
            got = outs();
            ev  = sb_q.pop_front();
            nm  = nm_q.pop_front();
            n_checks++;
            if (got !== ev) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b", nm, got, ev);
            end
        end
    endtask

    task automatic test_r0();
        stim_t s[2];
        logic [13:0] e[2];
        string n[2];
        logic [13:0] got;
        logic [13:0] ev;
        string nm;
        s[0] = '0; s[0].rw_m = 1; s[0].rw_w = 1;
        e[0] = 14'd0; n[0] = "r0_no_forward";
        s[1] = '0; s[1].m2r_e = 1; s[1].rw_e = 1; s[1].br_d = 1; s[1].m2r_m = 1;
        s[1].rw_m = 1;
        e[1] = 14'd0; n[1] = "r0_no_stall";
        for (int i = 0; i < 2; i++) begin
            drive(s[i], e[i], n[i]);
            got = outs();
            ev  = sb_q.pop_front();
            nm  = nm_q.pop_front();
            n_checks++;
            if (got !== ev) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b", nm, got, ev);
            end
        end
    endtask

    initial begin
        stim_t s0;
        n_checks = 0;
        n_errors = 0;
        s0 = '0;
        s0.rst_assert = 1'b1;
        apply(s0);
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_r0();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
